// File: rtl/radio_settings_arbiter_pkg.sv
// Shared radio definitions: settings-slot state encoding and index-width helper.
package radio_settings_arbiter_pkg;

  typedef enum logic {
    SlotIdle = 1'b0,
    SlotPend = 1'b1
  } slot_state_e;

  localparam int unsigned TimeW = 64;

  // Bits needed to index n entries; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/settings_rr_arbiter.sv
// Round-robin single-grant arbiter; the pointer remembers the last granted index.
module settings_rr_arbiter
  import radio_settings_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IdxW-1:0] last_q, last_d;

  always_comb begin
    int unsigned cand;
    cand        = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    // Walk last+1, last+2, ... wrapping, and take the first requester.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = 32'(last_q) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!gnt_valid_o && (i == cand) && req_i[i]) begin
          gnt_valid_o = 1'b1;
          gnt_o[i]    = 1'b1;
          gnt_idx_o   = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_valid_o) last_d = gnt_idx_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IdxW'(NumReq - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/radio_settings_arbiter.sv
// Per-channel one-entry settings slots, optionally timed, merged onto one settings bus.
module radio_settings_arbiter
  import radio_settings_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned AWIDTH       = 8,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned SRCW         = 3
) (
  input  logic                           ce_clk,
  input  logic                           ce_rst,
  input  logic [NUM_CHANNELS-1:0]        in_set_stb,
  input  logic [NUM_CHANNELS*AWIDTH-1:0] in_set_addr,
  input  logic [NUM_CHANNELS*DWIDTH-1:0] in_set_data,
  input  logic [NUM_CHANNELS*TimeW-1:0]  in_set_time,
  input  logic [NUM_CHANNELS-1:0]        in_set_has_time,
  input  logic [TimeW-1:0]               vita_time,
  output logic                           out_set_stb,
  output logic [AWIDTH-1:0]              out_set_addr,
  output logic [DWIDTH-1:0]              out_set_data,
  output logic [SRCW-1:0]                out_src,
  output logic [NUM_CHANNELS-1:0]        pending,
  output logic [NUM_CHANNELS-1:0]        late_stb,
  output logic [NUM_CHANNELS-1:0]        overflow_stb
);

  localparam int unsigned IdxW = idx_width(NUM_CHANNELS);

  slot_state_e        state_q [NUM_CHANNELS];
  slot_state_e        state_d [NUM_CHANNELS];
  logic [AWIDTH-1:0]  addr_q  [NUM_CHANNELS];
  logic [AWIDTH-1:0]  addr_d  [NUM_CHANNELS];
  logic [DWIDTH-1:0]  data_q  [NUM_CHANNELS];
  logic [DWIDTH-1:0]  data_d  [NUM_CHANNELS];
  logic [TimeW-1:0]   tm_q    [NUM_CHANNELS];
  logic [TimeW-1:0]   tm_d    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] has_time_q, has_time_d, late_q, late_d;
  logic [NUM_CHANNELS-1:0] eligible, gnt;
  logic [NUM_CHANNELS-1:0] overflow_q, overflow_d, late_stb_q, late_stb_d;
  logic                    gnt_valid;
  logic [IdxW-1:0]         gnt_idx;

  logic              out_stb_q, out_stb_d;
  logic [AWIDTH-1:0] out_addr_q, out_addr_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [SRCW-1:0]   out_src_q, out_src_d;

  always_comb begin
    eligible = '0;
    pending  = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      pending[i]  = (state_q[i] == SlotPend);
      eligible[i] = (state_q[i] == SlotPend) && (!has_time_q[i] || (vita_time >= tm_q[i]));
    end
  end

  settings_rr_arbiter #(
    .NumReq (NUM_CHANNELS),
    .IdxW   (IdxW)
  ) u_rr (
    .clk_i       (ce_clk),
    .rst_i       (ce_rst),
    .req_i       (eligible),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tm_d       = tm_q;
    has_time_d = has_time_q;
    late_d     = late_q;
    overflow_d = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (gnt[i]) state_d[i] = SlotIdle;
      // A slot being granted this cycle frees up in time to take a new strobe.
      if (in_set_stb[i]) begin
        if ((state_q[i] == SlotIdle) || gnt[i]) begin
          state_d[i]    = SlotPend;
          addr_d[i]     = in_set_addr[i*AWIDTH +: AWIDTH];
          data_d[i]     = in_set_data[i*DWIDTH +: DWIDTH];
          tm_d[i]       = in_set_time[i*TimeW +: TimeW];
          has_time_d[i] = in_set_has_time[i];
          late_d[i]     = in_set_has_time[i] && (in_set_time[i*TimeW +: TimeW] < vita_time);
        end else begin
          overflow_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_stb_d  = gnt_valid;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    late_stb_d = '0;
    if (gnt_valid) begin
      out_src_d = SRCW'(gnt_idx);
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (gnt[i]) begin
          out_addr_d    = addr_q[i];
          out_data_d    = data_q[i];
          late_stb_d[i] = late_q[i];
        end
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= SlotIdle;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        tm_q[i]    <= '0;
      end
      has_time_q <= '0;
      late_q     <= '0;
      overflow_q <= '0;
      late_stb_q <= '0;
      out_stb_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tm_q       <= tm_d;
      has_time_q <= has_time_d;
      late_q     <= late_d;
      overflow_q <= overflow_d;
      late_stb_q <= late_stb_d;
      out_stb_q  <= out_stb_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_set_stb  = out_stb_q;
  assign out_set_addr = out_addr_q;
  assign out_set_data = out_data_q;
  assign out_src      = out_src_q;
  assign late_stb     = late_stb_q;
  assign overflow_stb = overflow_q;

endmodule

// File: tb/tb_radio_settings_arbiter.sv
// Scoreboard bench for radio_settings_arbiter: expected issues queued at drive time.
module tb_radio_settings_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  logic              ce_clk = 1'b0;
  logic              ce_rst;
  logic [N-1:0]      in_set_stb;
  logic [N*AW-1:0]   in_set_addr;
  logic [N*DW-1:0]   in_set_data;
  logic [N*64-1:0]   in_set_time;
  logic [N-1:0]      in_set_has_time;
  logic [63:0]       vita_time;
  logic              out_set_stb;
  logic [AW-1:0]     out_set_addr;
  logic [DW-1:0]     out_set_data;
  logic [SW-1:0]     out_src;
  logic [N-1:0]      pending;
  logic [N-1:0]      late_stb;
  logic [N-1:0]      overflow_stb;

  radio_settings_arbiter #(
    .NUM_CHANNELS (N),
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .SRCW         (SW)
  ) dut (
    .ce_clk          (ce_clk),
    .ce_rst          (ce_rst),
    .in_set_stb      (in_set_stb),
    .in_set_addr     (in_set_addr),
    .in_set_data     (in_set_data),
    .in_set_time     (in_set_time),
    .in_set_has_time (in_set_has_time),
    .vita_time       (vita_time),
    .out_set_stb     (out_set_stb),
    .out_set_addr    (out_set_addr),
    .out_set_data    (out_set_data),
    .out_src         (out_src),
    .pending         (pending),
    .late_stb        (late_stb),
    .overflow_stb    (overflow_stb)
  );

  always #5 ce_clk = ~ce_clk;

  int unsigned cyc = 0;
  always @(posedge ce_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic [N-1:0]  late;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   ovf_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ce_clk);
  endtask

  task automatic set_stb(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [63:0] t, input logic ht);
    in_set_stb[ch]           = 1'b1;
    in_set_addr[ch*AW +: AW] = a;
    in_set_data[ch*DW +: DW] = d;
    in_set_time[ch*64 +: 64] = t;
    in_set_has_time[ch]      = ht;
  endtask

  task automatic clr_stb();
    in_set_stb = '0;
  endtask

  task automatic expect_iss(input int unsigned c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [N-1:0] l);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    e.src  = s;
    e.late = l;
    exp_q.push_back(e);
  endtask

  // Output monitor: every out_set_stb must match the head of the scoreboard.
  always @(negedge ce_clk) begin
    exp_t e;
    if (!ce_rst) begin
      ovf_cnt += $countones(overflow_stb);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_issue", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (out_set_stb) begin
        if (exp_q.size() == 0) begin
          check("spurious_stb", 64'(out_set_stb), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("iss_cyc", 64'(cyc), 64'(e.cyc));
          check("iss_addr", 64'(out_set_addr), 64'(e.addr));
          check("iss_data", 64'(out_set_data), 64'(e.data));
          check("iss_src", 64'(out_src), 64'(e.src));
          check("iss_late", 64'(late_stb), 64'(e.late));
        end
      end else if (late_stb != '0) begin
        check("late_idle", 64'(late_stb), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int          o0;
    ce_rst          = 1'b1;
    in_set_stb      = '0;
    in_set_addr     = '0;
    in_set_data     = '0;
    in_set_time     = '0;
    in_set_has_time = '0;
    vita_time       = '0;
    tick(3);
    check("rst_stb", 64'(out_set_stb), 64'd0);
    check("rst_addr", 64'(out_set_addr), 64'd0);
    check("rst_data", 64'(out_set_data), 64'd0);
    check("rst_src", 64'(out_src), 64'd0);
    check("rst_pend", 64'(pending), 64'd0);
    check("rst_late", 64'(late_stb), 64'd0);
    check("rst_ovf", 64'(overflow_stb), 64'd0);
    ce_rst = 1'b0;
    tick(2);

    // Untimed single command.
    c = cyc;
    set_stb(0, 8'h10, 32'hA5A5, 64'd0, 1'b0);
    expect_iss(c + 2, 8'h10, 32'hA5A5, 3'd0, 2'b00);
    tick(1);
    clr_stb();
    check("t1_pend", 64'(pending), 64'b01);
    tick(3);
    check("t1_idle", 64'(pending), 64'd0);
    check("hold_stb", 64'(out_set_stb), 64'd0);
    check("hold_addr", 64'(out_set_addr), 64'h10);
    check("hold_data", 64'(out_set_data), 64'hA5A5);

    // Timed command waits for vita_time to reach its time.
    vita_time = 64'd900;
    set_stb(1, 8'h21, 32'h1111, 64'd1000, 1'b1);
    tick(1);
    clr_stb();
    tick(3);
    check("t2_wait", 64'(pending), 64'b10);
    vita_time = 64'd999;
    tick(2);
    check("t2_wait999", 64'(pending), 64'b10);
    c = cyc;
    vita_time = 64'd1000;
    expect_iss(c + 1, 8'h21, 32'h1111, 3'd1, 2'b00);
    tick(3);
    check("t2_done", 64'(pending), 64'd0);

    // Contention twice, then rotation after a lone ch0 grant.
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      set_stb(0, 8'h30, 32'h3000 + r, 64'd0, 1'b0);
      set_stb(1, 8'h31, 32'h3100 + r, 64'd0, 1'b0);
      expect_iss(c + 2, 8'h30, 32'h3000 + r, 3'd0, 2'b00);
      expect_iss(c + 3, 8'h31, 32'h3100 + r, 3'd1, 2'b00);
      tick(1);
      clr_stb();
      tick(4);
    end
    c = cyc;
    set_stb(0, 8'h32, 32'h3200, 64'd0, 1'b0);
    expect_iss(c + 2, 8'h32, 32'h3200, 3'd0, 2'b00);
    tick(1);
    clr_stb();
    tick(3);
    c = cyc;
    set_stb(0, 8'h33, 32'h3300, 64'd0, 1'b0);
    set_stb(1, 8'h34, 32'h3400, 64'd0, 1'b0);
    expect_iss(c + 2, 8'h34, 32'h3400, 3'd1, 2'b00);
    expect_iss(c + 3, 8'h33, 32'h3300, 3'd0, 2'b00);
    tick(1);
    clr_stb();
    tick(4);

    // Late timed command still issues, flagged.
    vita_time = 64'd100;
    c = cyc;
    set_stb(0, 8'h40, 32'h4040, 64'd50, 1'b1);
    expect_iss(c + 2, 8'h40, 32'h4040, 3'd0, 2'b01);
    tick(1);
    clr_stb();
    tick(3);

    // Overflow: second strobe to a waiting slot is dropped.
    o0 = ovf_cnt;
    set_stb(0, 8'h50, 32'h5050, 64'd5000, 1'b1);
    tick(1);
    set_stb(0, 8'h51, 32'h5151, 64'd0, 1'b0);
    tick(1);
    clr_stb();
    check("ovf_pulse", 64'(overflow_stb), 64'b01);
    tick(1);
    check("ovf_once", 64'(overflow_stb), 64'd0);
    check("ovf_kept", 64'(pending), 64'b01);
    tick(3);
    check("ovf_count", 64'(ovf_cnt - o0), 64'd1);
    c = cyc;
    vita_time = 64'd6000;
    expect_iss(c + 1, 8'h50, 32'h5050, 3'd0, 2'b00);
    tick(3);
    check("ovf_done", 64'(pending), 64'd0);

    // Strobe into a slot granted the same cycle reloads it.
    o0 = ovf_cnt;
    c = cyc;
    set_stb(0, 8'h60, 32'h6060, 64'd0, 1'b0);
    tick(1);
    set_stb(0, 8'h61, 32'h6161, 64'd0, 1'b0);
    expect_iss(c + 2, 8'h60, 32'h6060, 3'd0, 2'b00);
    expect_iss(c + 3, 8'h61, 32'h6161, 3'd0, 2'b00);
    tick(1);
    clr_stb();
    tick(3);
    check("reload_noovf", 64'(ovf_cnt - o0), 64'd0);

    // Reset mid-operation discards pending work and ignores strobes under reset.
    vita_time = 64'd0;
    set_stb(0, 8'h70, 32'h7070, 64'd9999, 1'b1);
    set_stb(1, 8'h71, 32'h7171, 64'd9999, 1'b1);
    tick(1);
    clr_stb();
    tick(1);
    check("mid_pend2", 64'(pending), 64'b11);
    ce_rst = 1'b1;
    set_stb(0, 8'h72, 32'h7272, 64'd0, 1'b0);
    tick(1);
    ce_rst = 1'b0;
    clr_stb();
    vita_time = 64'd20000;
    check("mid_rst_pend", 64'(pending), 64'd0);
    tick(10);
    check("mid_still_idle", 64'(pending), 64'd0);
    check("mid_rst_addr", 64'(out_set_addr), 64'd0);

    c = cyc;
    set_stb(1, 8'h73, 32'h7373, 64'd0, 1'b0);
    expect_iss(c + 2, 8'h73, 32'h7373, 3'd1, 2'b00);
    tick(1);
    clr_stb();
    tick(5);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
